// File: rtl/riscv_debug_pkg.sv
// Shared types for the debug master/target bus: bus payload structs, op and
// register encodings, and the master FSM state type.
package riscv_debug_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 6;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned ARG_W  = 16;
    localparam int unsigned CNT_W  = 8;

    localparam logic [SEL_W-1:0] MASK_ALL = 6'h3f;

    typedef struct packed {
        logic              valid;
        logic [SEL_W-1:0]  select;
        logic [SEL_W-1:0]  mask;
        logic [OP_W-1:0]   op;
        logic [ARG_W-1:0]  arg;
        logic [DATA_W-1:0] data;
    } debug_mst_t;

    typedef struct packed {
        logic              valid;
        logic [SEL_W-1:0]  selected;
        logic              halted;
        logic              resumed;
        logic              hit_breakpoint;
        logic              op_was_none;
        logic              resp;
        logic [DATA_W-1:0] data;
        logic              attention;
    } debug_tgt_t;

    typedef enum logic [OP_W-1:0] {
        OP_CONTROL     = 4'd0,
        OP_WRITE_DATA0 = 4'd1
    } debug_op_e;

    // Argument layout for OP_CONTROL
    typedef struct packed {
        logic [13:0] rsvd;
        logic        resume_req;
        logic        halt_req;
    } control_arg_t;

    typedef enum logic [ADDR_W-1:0] {
        REG_CONTROL = 2'd0,
        REG_DATA    = 2'd1,
        REG_STATUS  = 2'd2,
        REG_COMMAND = 2'd3
    } reg_addr_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } dbg_state_e;

endpackage

// File: rtl/riscv_i32_debug_apb_regs.sv
// APB-visible register file of the debug master: CONTROL, DATA, sticky STATUS
// and the COMMAND strobe.
module riscv_i32_debug_apb_regs
    import riscv_debug_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [DATA_W-1:0] pwdata_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              cmd_write_o,
    output logic [SEL_W-1:0]  ctrl_select_o,
    output logic [OP_W-1:0]   ctrl_op_o,
    output logic [ARG_W-1:0]  ctrl_arg_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              busy_i,
    input  logic              start_i,
    input  logic              timeout_set_i,
    input  logic              overrun_set_i,
    input  logic              capture_i,
    input  logic              rsp_resp_i,
    input  logic              rsp_halted_i,
    input  logic              rsp_resumed_i,
    input  logic              rsp_hit_i,
    input  logic [SEL_W-1:0]  rsp_selected_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    input  logic              attn_load_i,
    input  logic              attn_i
);

    reg_addr_e         addr_c;
    logic              wr_c, rd_c, w1c_c;
    logic [DATA_W-1:0] status_c;

    logic [SEL_W-1:0]  ctrl_sel_q, ctrl_sel_d, rsp_sel_q, rsp_sel_d;
    logic [OP_W-1:0]   ctrl_op_q, ctrl_op_d;
    logic [ARG_W-1:0]  ctrl_arg_q, ctrl_arg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              timeout_q, timeout_d, overrun_q, overrun_d, attn_q, attn_d;
    logic              resp_q, resp_d, halted_q, halted_d;
    logic              resumed_q, resumed_d, hit_q, hit_d;

    assign addr_c = reg_addr_e'(paddr_i);
    assign wr_c   = psel_i & penable_i & pwrite_i;
    assign rd_c   = psel_i & penable_i & ~pwrite_i;
    assign w1c_c  = wr_c && (addr_c == REG_STATUS);

    assign cmd_write_o   = wr_c && (addr_c == REG_COMMAND);
    assign ctrl_select_o = ctrl_sel_q;
    assign ctrl_op_o     = ctrl_op_q;
    assign ctrl_arg_o    = ctrl_arg_q;
    assign wdata_o       = wdata_q;

    assign status_c = {18'b0, rsp_sel_q, overrun_q, attn_q, hit_q, resumed_q,
                       halted_q, resp_q, timeout_q, busy_i};

    // Next-state for all registers; hardware sets take priority over W1C
    always_comb begin
        ctrl_sel_d = ctrl_sel_q;
        ctrl_op_d  = ctrl_op_q;
        ctrl_arg_d = ctrl_arg_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rsp_sel_d  = rsp_sel_q;
        resp_d     = resp_q;
        halted_d   = halted_q;
        resumed_d  = resumed_q;
        hit_d      = hit_q;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q;
        attn_d     = attn_q;
        if (wr_c && (addr_c == REG_CONTROL)) begin
            ctrl_sel_d = pwdata_i[5:0];
            ctrl_op_d  = pwdata_i[11:8];
            ctrl_arg_d = pwdata_i[31:16];
        end
        if (wr_c && (addr_c == REG_DATA)) begin
            wdata_d = pwdata_i;
        end
        if (capture_i) begin
            rdata_d   = rsp_data_i;
            rsp_sel_d = rsp_selected_i;
            resp_d    = rsp_resp_i;
            halted_d  = rsp_halted_i;
            resumed_d = rsp_resumed_i;
            hit_d     = rsp_hit_i;
        end
        if (timeout_set_i) begin
            timeout_d = 1'b1;
        end else if (start_i || (w1c_c && pwdata_i[1])) begin
            timeout_d = 1'b0;
        end
        if (overrun_set_i) begin
            overrun_d = 1'b1;
        end else if (w1c_c && pwdata_i[7]) begin
            overrun_d = 1'b0;
        end
        if (attn_load_i) begin
            attn_d = attn_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_sel_q <= '0;
            ctrl_op_q  <= '0;
            ctrl_arg_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rsp_sel_q  <= '0;
            resp_q     <= 1'b0;
            halted_q   <= 1'b0;
            resumed_q  <= 1'b0;
            hit_q      <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            attn_q     <= 1'b0;
        end else begin
            ctrl_sel_q <= ctrl_sel_d;
            ctrl_op_q  <= ctrl_op_d;
            ctrl_arg_q <= ctrl_arg_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rsp_sel_q  <= rsp_sel_d;
            resp_q     <= resp_d;
            halted_q   <= halted_d;
            resumed_q  <= resumed_d;
            hit_q      <= hit_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            attn_q     <= attn_d;
        end
    end

    // Zero-wait-state read mux, only driven during a read access phase
    always_comb begin
        prdata_o = '0;
        if (rd_c) begin
            case (addr_c)
                REG_CONTROL: prdata_o = {ctrl_arg_q, 4'b0, ctrl_op_q, 2'b0, ctrl_sel_q};
                REG_DATA:    prdata_o = rdata_q;
                REG_STATUS:  prdata_o = status_c;
                default:     prdata_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/riscv_i32_debug_apb_master.sv
// Debug master: turns APB COMMAND writes into single-cycle debug_mst operations,
// waits for the selected target's response, and polls attention while idle.
module riscv_i32_debug_apb_master
    import riscv_debug_pkg::*;
#(
    parameter int unsigned timeout_cycles = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              apb_psel,
    input  logic              apb_penable,
    input  logic              apb_pwrite,
    input  logic [ADDR_W-1:0] apb_paddr,
    input  logic [DATA_W-1:0] apb_pwdata,
    output logic [DATA_W-1:0] apb_prdata,
    output logic              apb_pready,
    output logic              apb_perr,
    output logic              debug_mst__valid,
    output logic [SEL_W-1:0]  debug_mst__select,
    output logic [SEL_W-1:0]  debug_mst__mask,
    output logic [OP_W-1:0]   debug_mst__op,
    output logic [ARG_W-1:0]  debug_mst__arg,
    output logic [DATA_W-1:0] debug_mst__data,
    input  logic              debug_tgt__valid,
    input  logic [SEL_W-1:0]  debug_tgt__selected,
    input  logic              debug_tgt__halted,
    input  logic              debug_tgt__resumed,
    input  logic              debug_tgt__hit_breakpoint,
    input  logic              debug_tgt__op_was_none,
    input  logic              debug_tgt__resp,
    input  logic [DATA_W-1:0] debug_tgt__data,
    input  logic              debug_tgt__attention
);

    dbg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              prev_idle_q;

    debug_tgt_t        tgt_c;
    debug_mst_t        mst_c;
    logic              cmd_write_c, start_c, timeout_set_c, overrun_set_c, capture_c;
    logic [SEL_W-1:0]  ctrl_select_c;
    logic [OP_W-1:0]   ctrl_op_c;
    logic [ARG_W-1:0]  ctrl_arg_c;
    logic [DATA_W-1:0] wdata_c;
    logic              unused_tgt;

    always_comb begin
        tgt_c                = '0;
        tgt_c.valid          = debug_tgt__valid;
        tgt_c.selected       = debug_tgt__selected;
        tgt_c.halted         = debug_tgt__halted;
        tgt_c.resumed        = debug_tgt__resumed;
        tgt_c.hit_breakpoint = debug_tgt__hit_breakpoint;
        tgt_c.op_was_none    = debug_tgt__op_was_none;
        tgt_c.resp           = debug_tgt__resp;
        tgt_c.data           = debug_tgt__data;
        tgt_c.attention      = debug_tgt__attention;
    end
    assign unused_tgt = tgt_c.op_was_none;

    // Operation FSM: IDLE polls attention, ISSUE pulses valid, WAIT collects or times out
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        start_c       = 1'b0;
        timeout_set_c = 1'b0;
        capture_c     = 1'b0;
        mst_c         = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_write_c) begin
                    sel_d   = ctrl_select_c;
                    start_c = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mst_c.valid  = 1'b1;
                mst_c.select = sel_q;
                mst_c.mask   = MASK_ALL;
                mst_c.op     = ctrl_op_c;
                mst_c.arg    = ctrl_arg_c;
                mst_c.data   = wdata_c;
                cnt_d        = '0;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                mst_c.select = sel_q;
                mst_c.mask   = MASK_ALL;
                if (tgt_c.valid && (tgt_c.selected == sel_q)) begin
                    capture_c = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q == CNT_W'(timeout_cycles - 1)) begin
                    timeout_set_c = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign overrun_set_c = cmd_write_c && (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            prev_idle_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            prev_idle_q <= (state_q == ST_IDLE);
        end
    end

    assign debug_mst__valid  = mst_c.valid;
    assign debug_mst__select = mst_c.select;
    assign debug_mst__mask   = mst_c.mask;
    assign debug_mst__op     = mst_c.op;
    assign debug_mst__arg    = mst_c.arg;
    assign debug_mst__data   = mst_c.data;
    assign apb_pready        = 1'b1;
    assign apb_perr          = 1'b0;

    riscv_i32_debug_apb_regs u_regs (
        .clk            (clk),
        .reset_n        (reset_n),
        .psel_i         (apb_psel),
        .penable_i      (apb_penable),
        .pwrite_i       (apb_pwrite),
        .paddr_i        (apb_paddr),
        .pwdata_i       (apb_pwdata),
        .prdata_o       (apb_prdata),
        .cmd_write_o    (cmd_write_c),
        .ctrl_select_o  (ctrl_select_c),
        .ctrl_op_o      (ctrl_op_c),
        .ctrl_arg_o     (ctrl_arg_c),
        .wdata_o        (wdata_c),
        .busy_i         (state_q != ST_IDLE),
        .start_i        (start_c),
        .timeout_set_i  (timeout_set_c),
        .overrun_set_i  (overrun_set_c),
        .capture_i      (capture_c),
        .rsp_resp_i     (tgt_c.resp),
        .rsp_halted_i   (tgt_c.halted),
        .rsp_resumed_i  (tgt_c.resumed),
        .rsp_hit_i      (tgt_c.hit_breakpoint),
        .rsp_selected_i (tgt_c.selected),
        .rsp_data_i     (tgt_c.data),
        // Attention-enable in the targets is registered, so wait one idle cycle
        .attn_load_i    ((state_q == ST_IDLE) && prev_idle_q),
        .attn_i         (tgt_c.attention)
    );

endmodule

// File: doc/riscv_i32_debug_apb_master.md
# riscv_i32_debug_apb_master

Host-facing debug master that turns APB register accesses into single-cycle debug-bus operations on `debug_mst` and collects the registered responses returned on `debug_tgt` by the per-hart pipeline debug blocks. It sits directly upstream of those blocks: one master drives the broadcast `debug_mst` bus, and many targets return a wire-ORed `debug_tgt`. Between operations it polls all targets for attention and reports a sticky summary to the host.

## Interface
- `timeout_cycles`, default 15: number of WAIT cycles before an operation is abandoned; range 1..255.
- `clk`  in  1: clock, rising edge.
- `reset_n`  in  1: reset; asynchronous, active-low.
- `apb_psel`, `apb_penable`, `apb_pwrite`  in  1 each: APB request controls.
- `apb_paddr`  in  2: word address of the register.
- `apb_pwdata`  in  32: APB write data.
- `apb_prdata`  out  32: read data; 0 when the access is not a read.
- `apb_pready`  out  1: tied to 1.
- `apb_perr`  out  1: tied to 0.
- `debug_mst__valid`, `__select[5:0]`, `__mask[5:0]`, `__op[3:0]`, `__arg[15:0]`, `__data[31:0]`  out: debug bus to the targets.
- `debug_tgt__valid`, `__selected[5:0]`, `__halted`, `__resumed`, `__hit_breakpoint`, `__op_was_none`, `__resp`, `__data[31:0]`, `__attention`  in: wire-ORed target responses.

## Operation
Registers (access = psel & penable):
- 0 CONTROL, RW: `[5:0]` select, `[11:8]` op, `[31:16]` arg.
- 1 DATA:
  - write sets the outgoing data;
  - read returns the last response data.
- 2 STATUS: bits 1 and 7 are W1C; all other bits are read-only.
  - `[0]` busy, `[1]` timeout, `[2]` resp, `[3]` halted, `[4]` resumed, `[5]` hit_breakpoint, `[6]` attention, `[7]` overrun, `[13:8]` selected of the last response.
- 3 COMMAND, write-only, reads as 0:
  - any write in IDLE starts an operation;
  - a write when not IDLE is ignored and sets overrun.

FSM states (2 bits):
- IDLE:
  - drive select=0, mask=0, valid=0, so every target drives attention.
  - On a COMMAND write, clear timeout and go to ISSUE.
- ISSUE, exactly 1 cycle:
  - drive valid=1 with CONTROL select/op/arg and DATA data, and mask=6'h3f.
  - Clear the counter and go to WAIT.
- WAIT:
  - drive valid=0 and keep select and mask=6'h3f.
  - If `debug_tgt__valid` and `selected==select`: capture resp, halted, resumed, hit_breakpoint, selected and data; go to IDLE.
  - Else, if counter==timeout_cycles-1: set timeout and go to IDLE.
  - Else increment the counter.
- A response with a mismatched selected is ignored.

Attention:
- STATUS[6] is loaded from `debug_tgt__attention` only in IDLE cycles whose previous cycle was also IDLE. This allows for the targets' registered attention-enable.
- It holds its value otherwise.

Reset value of all registers, outputs and state is 0 (`apb_pready`=1).

## Timing
- APB has zero wait states. A register write takes effect at the edge that ends the access phase.
- CONTROL, DATA and COMMAND writes in the same cycle are impossible (single bus); the command uses the CONTROL/DATA values already held.
- Command write at edge N: busy=1 and `debug_mst__valid`=1 during cycle N+1; WAIT starts at cycle N+2.
- The normal target responds in cycle N+2. Status updates at the end of N+2, and busy reads 0 from N+3.
- Timeout: busy stays set for 1 + timeout_cycles cycles after the command.
- A W1C STATUS write and a hardware set of the same bit in the same cycle: the set wins.
- Reset asserted mid-operation: `debug_mst__valid` drops immediately, and all state returns to IDLE asynchronously.

## Structure
- Shared package `riscv_debug_pkg`:
  - `debug_mst`/`debug_tgt` struct typedefs;
  - op encodings (0 = control, arg[0] halt_req, arg[1] resume_req; 1 = write data0);
  - register address constants.
- FSM and counter live in the top module. The APB register file is one natural sub-module: `riscv_i32_debug_apb_regs`.

## Test plan
- Write CONTROL=0x0001_0003 (select 3, op 0, arg 1), then COMMAND: exactly one cycle of valid with select 3/op 0/arg 1. A target at rv_select 3 responds the next cycle; STATUS busy clears after 3 cycles.
- op 1, DATA=0xDEADBEEF to select 5; target responds with data 0xDEADBEEF. DATA reads 0xDEADBEEF and STATUS[13:8]=5.
- Command to absent select 9: no response, timeout set after 16 busy cycles. W1C 0x2 clears it.
- COMMAND written during WAIT: ignored, STATUS[7]=1, no second valid pulse.
- Target raises attention while the master is idle: STATUS[6]=1 within 2 cycles. During WAIT the bit does not change.
- Assert reset_n low during WAIT: outputs go to 0 immediately; after release, STATUS=0 and a new command works.
